// File: rtl/cim_pkg.sv
// Shared definitions for the CIM macro column-side blocks.
//   - default array geometry (columns, rows, row address width)
//   - operation mode encoding as presented on the mode input
//   - column reader FSM state type
package cim_pkg;

  localparam int N_COL_DEF = 4;
  localparam int N_ROW_DEF = 4;
  localparam int AW_DEF    = 2;

  localparam logic [1:0] MODE_READ = 2'b00;
  localparam logic [1:0] MODE_CAM  = 2'b01;
  localparam logic [1:0] MODE_MAC  = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/cim_prio_enc.sv
// Lowest-index priority encoder with any-hit flag.
// Ports:
//   i_req  [N-1:0]   request / match vector
//   o_any            at least one request bit set
//   o_idx  [AW-1:0]  index of lowest set bit, 0 when none set
module cim_prio_enc #(
  parameter int N  = 4,
  parameter int AW = 2
) (
  input  logic [N-1:0]  i_req,
  output logic          o_any,
  output logic [AW-1:0] o_idx
);

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = AW'(i);
    end
  end

endmodule

// File: rtl/cim_col_reader.sv
// Column-side readout sequencer for the 4x4 CIM macro.
// Per operation: raise the WL strobe, wait SETTLE_CYC cycles for bitlines /
// match lines to settle, sample once, then present the result on a
// valid/ready handshake. MAC repeats settle+sample mac_len+1 times and
// accumulates a saturating popcount.
// Optional feature macro: CIM_COL_MULTI_HIT_EN (builds the multi_hit flag;
// otherwise multi_hit is tied 0).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cs                  chip select, low aborts any operation
//   start, mode         request (sampled in IDLE) and mode 00/01/10
//   read_bar, mac_len   MAC source select and step count - 1
//   sa_bl, sa_blb, ml   sense-amp and match-line inputs
//   busy, wl_fire       status / WL strobe enable
//   out_valid/out_ready result handshake
//   rd_data, sa_err     READ result
//   hit, hit_addr       CAM result
//   multi_hit           CAM multiple-match flag
//   mac_acc             MAC accumulated popcount
module cim_col_reader
  import cim_pkg::*;
#(
  parameter int N_COL      = N_COL_DEF,
  parameter int N_ROW      = N_ROW_DEF,
  parameter int AW         = AW_DEF,
  parameter int ACC_W      = 6,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             read_bar,
  input  logic [2:0]       mac_len,
  input  logic [N_COL-1:0] sa_bl,
  input  logic [N_COL-1:0] sa_blb,
  input  logic [N_ROW-1:0] ml,
  output logic             busy,
  output logic             wl_fire,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_COL-1:0] rd_data,
  output logic             sa_err,
  output logic             hit,
  output logic [AW-1:0]    hit_addr,
  output logic             multi_hit,
  output logic [ACC_W-1:0] mac_acc
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int PW = $clog2(N_COL + 1);
  localparam logic [ACC_W:0] ACC_MAX = {1'b0, {ACC_W{1'b1}}};

  state_t           r_state, w_nxt;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_step, r_len;
  logic [1:0]       r_mode;
  logic             r_rdbar;
  logic [N_COL-1:0] r_rd;
  logic             r_err, r_hit;
  logic [AW-1:0]    r_addr;
  logic [ACC_W-1:0] r_acc;

  logic             w_start_ok, w_settled, w_last_step;
  logic             w_pe_any;
  logic [AW-1:0]    w_pe_idx;
  logic [N_COL-1:0] w_mac_src;
  logic [PW-1:0]    w_pop;
  logic [ACC_W:0]   w_sum;

  assign w_start_ok  = start & cs & (mode != MODE_RSVD);
  assign w_settled   = (r_cnt == CW'(SETTLE_CYC - 1));
  assign w_last_step = (r_mode != MODE_MAC) || (r_step == r_len);

  cim_prio_enc #(.N(N_ROW), .AW(AW)) u_prio (
    .i_req (ml),
    .o_any (w_pe_any),
    .o_idx (w_pe_idx)
  );

  // Popcount of the selected bitline side; one extra accumulator bit
  // exposes overflow for saturation.
  always_comb begin
    w_mac_src = r_rdbar ? sa_blb : sa_bl;
    w_pop     = '0;
    for (int i = 0; i < N_COL; i++) w_pop = w_pop + PW'(w_mac_src[i]);
    w_sum = {1'b0, r_acc} + (ACC_W + 1)'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_ok) w_nxt = ST_SETTLE;
      ST_SETTLE: if (w_settled) w_nxt = ST_SAMPLE;
      // MAC steps loop straight back to SETTLE so wl_fire never drops.
      ST_SAMPLE: w_nxt = w_last_step ? ST_DONE : ST_SETTLE;
      ST_DONE:   if (out_ready) w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
    if (!cs && r_state != ST_IDLE) w_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_step  <= '0;
      r_len   <= '0;
      r_mode  <= MODE_READ;
      r_rdbar <= 1'b0;
      r_rd    <= '0;
      r_err   <= 1'b0;
      r_hit   <= 1'b0;
      r_addr  <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_mode  <= mode;
            r_rdbar <= read_bar;
            r_len   <= mac_len;
            r_cnt   <= '0;
            r_step  <= '0;
            if (mode == MODE_MAC) r_acc <= '0;
          end
        end
        ST_SETTLE: r_cnt <= r_cnt + CW'(1);
        ST_SAMPLE: begin
          // An abort on the sampling edge discards the sample.
          if (cs) begin
            r_cnt <= '0;
            case (r_mode)
              MODE_READ: begin
                r_rd  <= sa_bl;
                r_err <= |(~(sa_bl ^ sa_blb));
              end
              MODE_CAM: begin
                r_hit  <= w_pe_any;
                r_addr <= w_pe_idx;
              end
              MODE_MAC: begin
                r_acc  <= (w_sum > ACC_MAX) ? ACC_MAX[ACC_W-1:0] : w_sum[ACC_W-1:0];
                r_step <= r_step + 3'd1;
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CIM_COL_MULTI_HIT_EN
  localparam int MW = $clog2(N_ROW + 1);
  logic [MW-1:0] w_ml_pop;
  logic          r_multi;

  always_comb begin
    w_ml_pop = '0;
    for (int i = 0; i < N_ROW; i++) w_ml_pop = w_ml_pop + MW'(ml[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) r_multi <= 1'b0;
    else if (r_state == ST_SAMPLE && cs && r_mode == MODE_CAM)
      r_multi <= (w_ml_pop >= MW'(2));
  end

  assign multi_hit = r_multi;
`else
  assign multi_hit = 1'b0;
`endif

  assign busy      = (r_state != ST_IDLE);
  assign wl_fire   = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
  assign out_valid = (r_state == ST_DONE);
  assign rd_data   = r_rd;
  assign sa_err    = r_err;
  assign hit       = r_hit;
  assign hit_addr  = r_addr;
  assign mac_acc   = r_acc;

endmodule

// File: tb/tb_cim_col_reader.sv
// Bench for cim_col_reader: directed vectors, a timeline-based reference
// model checked every cycle, and hand-computed literal expectations.
// Two instances share stimulus: ACC_W=6 (main) and ACC_W=4 (saturation).
module tb_cim_col_reader;

  localparam int SC = 1;

  logic       clk = 1'b0;
  logic       rst, cs, start, read_bar, out_ready;
  logic [1:0] mode;
  logic [2:0] mac_len;
  logic [3:0] sa_bl, sa_blb, ml;

  logic       busy, wl_fire, out_valid, sa_err, hit, multi_hit;
  logic [3:0] rd_data;
  logic [1:0] hit_addr;
  logic [5:0] mac_acc;

  logic       busy4, wl4, valid4, err4, hit4, multi4;
  logic [3:0] rd4;
  logic [1:0] addr4;
  logic [3:0] acc4;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cim_col_reader #(.N_COL(4), .N_ROW(4), .AW(2), .ACC_W(6), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .cs(cs), .start(start), .mode(mode), .read_bar(read_bar),
    .mac_len(mac_len), .sa_bl(sa_bl), .sa_blb(sa_blb), .ml(ml), .busy(busy),
    .wl_fire(wl_fire), .out_valid(out_valid), .out_ready(out_ready), .rd_data(rd_data),
    .sa_err(sa_err), .hit(hit), .hit_addr(hit_addr), .multi_hit(multi_hit), .mac_acc(mac_acc)
  );

  cim_col_reader #(.N_COL(4), .N_ROW(4), .AW(2), .ACC_W(4), .SETTLE_CYC(SC)) dut4 (
    .clk(clk), .rst(rst), .cs(cs), .start(start), .mode(mode), .read_bar(read_bar),
    .mac_len(mac_len), .sa_bl(sa_bl), .sa_blb(sa_blb), .ml(ml), .busy(busy4),
    .wl_fire(wl4), .out_valid(valid4), .out_ready(out_ready), .rd_data(rd4),
    .sa_err(err4), .hit(hit4), .hit_addr(addr4), .multi_hit(multi4), .mac_acc(acc4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (operation timeline) ----------------
  function automatic int lat(input logic [1:0] md, input logic [2:0] len);
    return (md == 2'b10) ? (int'(len) + 1) * (SC + 1) + 1 : SC + 2;
  endfunction

  function automatic int pop4(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic int first_one(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic bit any_equal(input logic [3:0] a, input logic [3:0] b);
    for (int i = 0; i < 4; i++) if (a[i] == b[i]) return 1'b1;
    return 1'b0;
  endfunction

  bit         m_busy, m_rdbar, m_err, m_hit, m_multi;
  int         m_t, m_addr, m_acc6, m_acc4;
  logic [1:0] m_mode;
  logic [2:0] m_len;
  logic [3:0] m_rd;

  // m_t counts cycles since the accepted start edge; samples happen on
  // every multiple of SC+1, the result is offered at m_t == lat.
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_t <= 0; m_mode <= 0; m_len <= 0; m_rdbar <= 0;
      m_rd <= 0; m_err <= 0; m_hit <= 0; m_addr <= 0; m_multi <= 0;
      m_acc6 <= 0; m_acc4 <= 0;
    end else if (!m_busy) begin
      if (start && cs && mode != 2'b11) begin
        m_busy <= 1; m_t <= 1; m_mode <= mode; m_len <= mac_len; m_rdbar <= read_bar;
        if (mode == 2'b10) begin m_acc6 <= 0; m_acc4 <= 0; end
      end
    end else if (!cs) begin
      m_busy <= 0;
    end else if (m_t == lat(m_mode, m_len)) begin
      if (out_ready) m_busy <= 0;
    end else begin
      m_t <= m_t + 1;
      if (m_t % (SC + 1) == 0) begin
        case (m_mode)
          2'b00: begin m_rd <= sa_bl; m_err <= any_equal(sa_bl, sa_blb); end
          2'b01: begin
            m_hit <= (ml != 0); m_addr <= first_one(ml); m_multi <= (pop4(ml) >= 2);
          end
          default: begin
            m_acc6 <= (m_acc6 + pop4(m_rdbar ? sa_blb : sa_bl) > 63) ? 63 :
                      m_acc6 + pop4(m_rdbar ? sa_blb : sa_bl);
            m_acc4 <= (m_acc4 + pop4(m_rdbar ? sa_blb : sa_bl) > 15) ? 15 :
                      m_acc4 + pop4(m_rdbar ? sa_blb : sa_bl);
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",      busy,      m_busy);
      chk("wl_fire",   wl_fire,   m_busy && m_t < lat(m_mode, m_len));
      chk("out_valid", out_valid, m_busy && m_t == lat(m_mode, m_len));
      chk("rd_data",   rd_data,   m_rd);
      chk("sa_err",    sa_err,    m_err);
      chk("hit",       hit,       m_hit);
      chk("hit_addr",  hit_addr,  m_addr);
`ifdef CIM_COL_MULTI_HIT_EN
      chk("multi_hit", multi_hit, m_multi);
`else
      chk("multi_hit", multi_hit, 0);
`endif
      chk("mac_acc",   mac_acc,   m_acc6);
      chk("mac_acc4",  acc4,      m_acc4);
      chk("busy4",     busy4,     m_busy);
      chk("valid4",    valid4,    m_busy && m_t == lat(m_mode, m_len));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [1:0] md, input logic rb, input logic [2:0] len,
                        input int exp_lat, input string nm);
    int n;
    mode = md; read_bar = rb; mac_len = len; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!out_valid && n < 60) begin tick(); n++; end
    chk({nm, "_lat"}, n, exp_lat);
  endtask

  task automatic accept();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; cs = 0; start = 0; mode = 0; read_bar = 0; mac_len = 0;
    sa_bl = 0; sa_blb = 0; ml = 0; out_ready = 0;
    tick(); chk_en = 1'b1; tick();
    chk("rst_busy", busy, 0); chk("rst_valid", out_valid, 0); chk("rst_acc", mac_acc, 0);
    rst = 0; cs = 1;

    // READ: strobe in cycles 1-2, result in cycle 3, held while not ready
    sa_bl = 4'b1010; sa_blb = 4'b0101; mode = 2'b00; start = 1;
    tick(); start = 0;
    chk("rd_wl_c1", wl_fire, 1);
    tick();
    chk("rd_wl_c2", wl_fire, 1); chk("rd_v_c2", out_valid, 0);
    tick();
    chk("rd_v_c3", out_valid, 1); chk("rd_wl_c3", wl_fire, 0);
    chk("rd_data_lit", rd_data, 4'b1010); chk("rd_err_lit", sa_err, 0);
    tick(); tick();
    chk("rd_hold_v", out_valid, 1); chk("rd_hold_d", rd_data, 4'b1010);
    // accept with start in the same cycle: start must be ignored
    out_ready = 1; start = 1; tick(); out_ready = 0; start = 0;
    chk("done_start_ign", busy, 0);
    tick(); chk("done_start_ign2", busy, 0);

    // READ with sense conflict
    sa_bl = 4'b1100; sa_blb = 4'b1101;
    run_op(2'b00, 0, 0, 3, "rd2");
    chk("rd2_err_lit", sa_err, 1); chk("rd2_data_lit", rd_data, 4'b1100);
    accept();

    // CAM two matches, then no match
    ml = 4'b0110;
    run_op(2'b01, 0, 0, 3, "cam1");
    chk("cam1_hit_lit", hit, 1); chk("cam1_addr_lit", hit_addr, 1);
`ifdef CIM_COL_MULTI_HIT_EN
    chk("cam1_multi_lit", multi_hit, 1);
`else
    chk("cam1_multi_lit", multi_hit, 0);
`endif
    accept();
    ml = 4'b0000;
    run_op(2'b01, 0, 0, 3, "cam2");
    chk("cam2_hit_lit", hit, 0); chk("cam2_addr_lit", hit_addr, 0);
    accept();

    // MAC 3 steps on BL side, then BLB side
    sa_bl = 4'b0111; sa_blb = 4'b0000;
    run_op(2'b10, 0, 3'd2, 7, "mac1");
    chk("mac1_acc_lit", mac_acc, 9); chk("mac1_model_lit", m_acc6, 9);
    accept();
    sa_bl = 4'b0000; sa_blb = 4'b1111;
    run_op(2'b10, 1, 3'd2, 7, "mac2");
    chk("mac2_acc_lit", mac_acc, 12); chk("mac2_acc4_lit", acc4, 12);
    accept();

    // MAC saturation: 8 steps x 4 = 32; ACC_W=4 clamps at 15
    sa_bl = 4'b1111; sa_blb = 4'b0000;
    run_op(2'b10, 0, 3'd7, 17, "mac3");
    chk("mac3_acc_lit", mac_acc, 32); chk("mac3_acc4_lit", acc4, 15);
    chk("mac3_model_lit", m_acc4, 15);
    accept();

    // Abort during SETTLE of a READ
    sa_bl = 4'b0011; sa_blb = 4'b1100; mode = 2'b00; start = 1;
    tick(); start = 0; cs = 0;
    tick();
    chk("abort_busy", busy, 0);
    cs = 1;
    repeat (4) begin tick(); chk("abort_novalid", out_valid, 0); end
    chk("abort_rd_hold", rd_data, 4'b1100);

    // Reset in the middle of a MAC
    sa_bl = 4'b1111;
    mode = 2'b10; mac_len = 3'd7; read_bar = 0; start = 1;
    tick(); start = 0;
    tick(); tick(); tick();
    rst = 1; tick();
    chk("rstmid_busy", busy, 0); chk("rstmid_wl", wl_fire, 0);
    chk("rstmid_acc", mac_acc, 0); chk("rstmid_rd", rd_data, 0);
    chk("rstmid_hit", hit, 0);
    rst = 0;

    // Reserved mode is ignored
    mode = 2'b11; start = 1;
    tick(); tick();
    start = 0;
    chk("rsvd_busy", busy, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
